load_store_unit: RTL and testbench

- Initiator side of the data-memory interface in the MIPS datapath.
- Accepts one load/store request at a time from the execute stage and sequences MemRead/MemWrite cycles to the byte-addressed, little-endian, word-access data memory.
- Loads: extracts the byte/half lane and sign/zero-extends it.
- Sub-word stores: performs read-modify-write, because the memory only writes whole 4-byte words.

---
 rtl/lsu_pkg.sv | 59 +++++
 rtl/load_store_unit.sv | 135 +++++++++++++
 tb/tb_load_store_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states and
// the combinational lane extract/merge helpers (fixed at 4 byte lanes).
package lsu_pkg;

  localparam int unsigned LSU_DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_MERGE,
    ST_WRITE,
    ST_DONE
  } lsu_state_e;

  // Pick the addressed byte/half out of a memory word and extend it.
  function automatic logic [LSU_DATA_W-1:0] lane_extract(
    input logic [LSU_DATA_W-1:0] word,
    input logic [1:0]            addr_lo,
    input logic [1:0]            size,
    input logic                  is_unsigned
  );
    logic [7:0]            b;
    logic [15:0]           h;
    logic [LSU_DATA_W-1:0] res;
    b = word[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: res = is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: res = is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace only the addressed byte/half of a memory word with store data.
  function automatic logic [LSU_DATA_W-1:0] lane_merge(
    input logic [LSU_DATA_W-1:0] word,
    input logic [LSU_DATA_W-1:0] wdata,
    input logic [1:0]            addr_lo,
    input logic [1:0]            size
  );
    logic [LSU_DATA_W-1:0] res;
    res = word;
    case (size)
      SZ_BYTE: res[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (addr_lo[1]) res[31:16] = wdata[15:0];
        else            res[15:0]  = wdata[15:0];
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of a word-access, little-endian data memory.
// Loads read one word and extract/extend the lane; sub-word stores do a
// read-modify-write; misaligned or illegal-size requests finish with err.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we/size/unsigned/addr/wdata  request payload
//   done, err, rdata           completion pulse, error flag, load result
//   mem_address/read/write/write_data, mem_read_data  data memory side
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32  // lane logic assumes exactly 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_e r_state, w_state_nxt;

  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_accept;
  logic              w_misalign;
  logic [ADDR_W-1:0] w_addr_src;
  logic [ADDR_W-1:0] w_mem_address_nxt;
  logic [DATA_W-1:0] w_mem_wdata_nxt;
  logic              w_rdata_load;

  assign w_accept   = req_valid && req_ready;
  assign w_misalign = (req_size == 2'b11) ||
                      ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  // On the accept edge the captured address is not yet registered.
  assign w_addr_src = w_accept ? req_addr : r_addr;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and next values of the registered outputs
  always_comb begin
    w_state_nxt       = r_state;
    w_mem_address_nxt = '0;
    w_mem_wdata_nxt   = mem_write_data;
    w_rdata_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_misalign)                        w_state_nxt = ST_DONE;
          else if (req_we && req_size == SZ_WORD) w_state_nxt = ST_WRITE;
          else                                   w_state_nxt = ST_READ;
        end
      end
      ST_READ:  w_state_nxt = ST_MERGE;
      ST_MERGE: begin
        w_state_nxt  = r_we ? ST_WRITE : ST_DONE;
        w_rdata_load = !r_we;
      end
      ST_WRITE: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_state_nxt == ST_READ || w_state_nxt == ST_WRITE)
      w_mem_address_nxt = {w_addr_src[ADDR_W-1:2], 2'b00};
    // Word stores write straight from the request; sub-word stores merge.
    if (w_state_nxt == ST_WRITE)
      w_mem_wdata_nxt = w_accept ? req_wdata
                      : lane_merge(mem_read_data, r_wdata, r_addr[1:0], r_size);
  end

  // Request capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else if (w_accept) begin
      r_we       <= req_we;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready      <= 1'b1;
      done           <= 1'b0;
      err            <= 1'b0;
      rdata          <= '0;
      mem_address    <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_write_data <= '0;
    end else begin
      req_ready      <= (w_state_nxt == ST_IDLE);
      done           <= (w_state_nxt == ST_DONE);
      err            <= w_accept && w_misalign;
      mem_address    <= w_mem_address_nxt;
      mem_read       <= (w_state_nxt == ST_READ);
      mem_write      <= (w_state_nxt == ST_WRITE);
      mem_write_data <= w_mem_wdata_nxt;
      if (w_rdata_load)
        rdata <= lane_extract(mem_read_data, r_addr[1:0], r_size, r_unsigned);
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word-access memory.
module tb_load_store_unit;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              done, err;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read, mem_write;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data = '0;

  load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .err(err), .rdata(rdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Data memory: 8 words, word i initialised to byte (i+3) in every lane.
  logic [31:0] mem [8];
  bit          mem_inited = 1'b0;
  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 8; i++) mem[i] <= {4{8'(i + 3)}};
      mem_inited <= 1'b1;
    end else begin
      if (mem_write) mem[mem_address[4:2]] <= mem_write_data;
      if (mem_read)  mem_read_data <= mem[mem_address[4:2]];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  int          lat, rd_cnt, wr_cnt, both_cnt;
  logic [31:0] rd_addr, wr_addr, wr_data, got_rdata;
  logic        got_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and watch the memory side until done (bounded).
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [ADDR_W-1:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
    rd_addr = '1; wr_addr = '1; wr_data = '0; got_err = 1'b0; got_rdata = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_read)  begin rd_cnt++; rd_addr = 32'(mem_address); end
      if (mem_write) begin wr_cnt++; wr_addr = 32'(mem_address); wr_data = mem_write_data; end
      if (mem_read && mem_write) both_cnt++;
      if (done) begin
        lat = c; got_err = err; got_rdata = rdata;
        break;
      end
    end
    if (lat == 0) check("done_timeout", 32'(lat), 32'd1);
  endtask

  task automatic load(input string tag, input logic [1:0] size, input logic uns,
                      input logic [ADDR_W-1:0] addr, input logic [31:0] exp);
    do_req(1'b0, size, uns, addr, '0);
    check({tag, "_rdata"}, got_rdata, exp);
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_rd_cnt"}, 32'(rd_cnt), 32'd1);
    check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd0);
    check({tag, "_err"}, 32'(got_err), 32'd0);
  endtask

  task automatic bad(input string tag, input logic [1:0] size,
                     input logic [ADDR_W-1:0] addr, input logic [31:0] prev);
    do_req(1'b0, size, 1'b0, addr, '0);
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check({tag, "_err"}, 32'(got_err), 32'd1);
    check({tag, "_mem_cnt"}, 32'(rd_cnt + wr_cnt), 32'd0);
    check({tag, "_rdata"}, got_rdata, prev);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_addr", 32'(mem_address), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // Word store
    do_req(1'b1, 2'b10, 1'b0, 5'd8, 32'hDEADBEEF);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_wr_cnt", 32'(wr_cnt), 32'd1);
    check("sw_rd_cnt", 32'(rd_cnt), 32'd0);
    check("sw_addr", wr_addr, 32'd8);
    check("sw_data", wr_data, 32'hDEADBEEF);
    check("sw_err", 32'(got_err), 32'd0);
    check("sw_rdata", got_rdata, 32'h0);

    // Loads of every size
    load("lw8", 2'b10, 1'b0, 5'd8, 32'hDEADBEEF);
    check("lw8_rd_addr", rd_addr, 32'd8);
    load("lb11", 2'b00, 1'b0, 5'd11, 32'hFFFFFFDE);
    load("lbu11", 2'b00, 1'b1, 5'd11, 32'h000000DE);
    load("lh10", 2'b01, 1'b0, 5'd10, 32'hFFFFDEAD);
    load("lhu8", 2'b01, 1'b1, 5'd8, 32'h0000BEEF);
    check("lhu8_rd_addr", rd_addr, 32'd8);

    // Byte store: read-modify-write
    do_req(1'b1, 2'b00, 1'b0, 5'd9, 32'h12345655);
    check("sb_lat", 32'(lat), 32'd4);
    check("sb_rd_cnt", 32'(rd_cnt), 32'd1);
    check("sb_wr_cnt", 32'(wr_cnt), 32'd1);
    check("sb_both", 32'(both_cnt), 32'd0);
    check("sb_rd_addr", rd_addr, 32'd8);
    check("sb_wr_addr", wr_addr, 32'd8);
    check("sb_wr_data", wr_data, 32'hDEAD55EF);
    check("sb_rdata_kept", got_rdata, 32'h0000BEEF);
    load("lw8b", 2'b10, 1'b0, 5'd8, 32'hDEAD55EF);

    // Half store into the upper lane
    do_req(1'b1, 2'b01, 1'b0, 5'd10, 32'hFFFF1234);
    check("sh_lat", 32'(lat), 32'd4);
    check("sh_wr_data", wr_data, 32'h123455EF);

    // Errors
    bad("lw6", 2'b10, 5'd6, 32'hDEAD55EF);
    bad("lh3", 2'b01, 5'd3, 32'hDEAD55EF);
    bad("sz11", 2'b11, 5'd0, 32'hDEAD55EF);

    // Reset during MERGE of a byte store must suppress the write
    wr_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 5'd0; req_wdata = 32'h000000AA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    if (mem_write) wr_cnt++;
    @(negedge clk);
    if (mem_write) wr_cnt++;
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_write", 32'(mem_write), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    repeat (2) begin
      @(negedge clk);
      if (mem_write) wr_cnt++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (mem_write) wr_cnt++;
    end
    check("rst_mid_wr_cnt", 32'(wr_cnt), 32'd0);
    check("rst_mid_ready_after", 32'(req_ready), 32'd1);
    load("lw0", 2'b10, 1'b0, 5'd0, 32'h03030303);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
